// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state one-hot ring clocked on the falling edge, decoding opcode into bus control words.
// Optional JMP (opcode 0011) is enabled by defining SAP1_JMP_EN; otherwise n_load_pc stays high.
module sap1_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    output logic       pc_inc,
    output logic       pc_en,
    output logic       n_load_pc,
    output logic       n_load_mar,
    output logic       n_enable_ram,
    output logic       n_load_ir,
    output logic       n_enable_ir,
    output logic       n_load_a,
    output logic       a_en,
    output logic       sub,
    output logic       alu_en,
    output logic       n_load_b,
    output logic       n_load_out,
    output logic       halt,
    output logic [5:0] t_state
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    ring_t ring_q, ring_d;
    logic  halted_q, halted_d;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_q   <= T1;
            halted_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
        end
    end

    // HLT freezes the ring at T4; only reset clears the halted flag.
    always_comb begin
        ring_d   = ring_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (ring_q == T4 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                case (ring_q)
                    T1:      ring_d = T2;
                    T2:      ring_d = T3;
                    T3:      ring_d = T4;
                    T4:      ring_d = T5;
                    T5:      ring_d = T6;
                    T6:      ring_d = T1;
                    default: ring_d = T1;
                endcase
            end
        end
    end

    always_comb begin
        pc_inc       = 1'b0;
        pc_en        = 1'b0;
        n_load_pc    = 1'b1;
        n_load_mar   = 1'b1;
        n_enable_ram = 1'b1;
        n_load_ir    = 1'b1;
        n_enable_ir  = 1'b1;
        n_load_a     = 1'b1;
        a_en         = 1'b0;
        sub          = 1'b0;
        alu_en       = 1'b0;
        n_load_b     = 1'b1;
        n_load_out   = 1'b1;
        halt         = halted_q;
        if (!halted_q) begin
            case (ring_q)
                T1: begin
                    pc_en      = 1'b1;
                    n_load_mar = 1'b0;
                end
                T2: pc_inc = 1'b1;
                T3: begin
                    n_enable_ram = 1'b0;
                    n_load_ir    = 1'b0;
                end
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            n_enable_ir = 1'b0;
                            n_load_mar  = 1'b0;
                        end
                        OP_OUT: begin
                            a_en       = 1'b1;
                            n_load_out = 1'b0;
                        end
                        OP_HLT: halt = 1'b1;
`ifdef SAP1_JMP_EN
                        OP_JMP: begin
                            n_enable_ir = 1'b0;
                            n_load_pc   = 1'b0;
                        end
`endif
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA: begin
                            n_enable_ram = 1'b0;
                            n_load_a     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            n_enable_ram = 1'b0;
                            n_load_b     = 1'b0;
                            sub          = (opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_en   = 1'b1;
                        n_load_a = 1'b0;
                        sub      = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state = ring_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Randomized scoreboard bench for sap1_controller; the driver queues expected control words, a posedge monitor compares.
module tb_sap1_controller;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       pc_inc, pc_en, n_load_pc, n_load_mar, n_enable_ram, n_load_ir, n_enable_ir;
  logic       n_load_a, a_en, sub, alu_en, n_load_b, n_load_out, halt;
  logic [5:0] t_state;

  // clock/reset block: sequencer moves on negedge, monitor samples on posedge
  always #5 clk = ~clk;

  sap1_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .pc_inc(pc_inc), .pc_en(pc_en), .n_load_pc(n_load_pc), .n_load_mar(n_load_mar),
    .n_enable_ram(n_enable_ram), .n_load_ir(n_load_ir), .n_enable_ir(n_enable_ir),
    .n_load_a(n_load_a), .a_en(a_en), .sub(sub), .alu_en(alu_en), .n_load_b(n_load_b),
    .n_load_out(n_load_out), .halt(halt), .t_state(t_state)
  );

  // word = {halt, t_state, 13 control lines in port order}
  logic [19:0] act_word;
  assign act_word = {halt, t_state, pc_inc, pc_en, n_load_pc, n_load_mar, n_enable_ram, n_load_ir,
                     n_enable_ir, n_load_a, a_en, sub, alu_en, n_load_b, n_load_out};

  localparam int CP = 12, EP = 11, LP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;
  localparam logic [12:0] ACT_LOW = 13'b0011111100011;

  int n_checks = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];
  string       tag_q[$];

  // reference model: set of logically asserted signals per step, then mapped to pin polarity
  function automatic logic [19:0] model_word(int step, logic [3:0] op, bit halted);
    logic [12:0] on;
    logic        h;
    logic [5:0]  ts;
    on = '0;
    h  = halted;
    ts = 6'b001000;
    if (!halted) begin
      ts = 6'(1 << (step - 1));
      if (step == 1) begin on[EP] = 1'b1; on[LM] = 1'b1; end
      if (step == 2) on[CP] = 1'b1;
      if (step == 3) begin on[CE] = 1'b1; on[LI] = 1'b1; end
      if (step == 4) begin
        if (op == 4'd0 || op == 4'd1 || op == 4'd2) begin on[EI] = 1'b1; on[LM] = 1'b1; end
        if (op == 4'd14) begin on[EA] = 1'b1; on[LO] = 1'b1; end
        if (op == 4'd15) h = 1'b1;
`ifdef SAP1_JMP_EN
        if (op == 4'd3) begin on[EI] = 1'b1; on[LP] = 1'b1; end
`endif
      end
      if (step == 5) begin
        if (op == 4'd0) begin on[CE] = 1'b1; on[LA] = 1'b1; end
        if (op == 4'd1 || op == 4'd2) begin on[CE] = 1'b1; on[LB] = 1'b1; end
        if (op == 4'd2) on[SU] = 1'b1;
      end
      if (step == 6) begin
        if (op == 4'd1 || op == 4'd2) begin on[EU] = 1'b1; on[LA] = 1'b1; end
        if (op == 4'd2) on[SU] = 1'b1;
      end
    end
    return {h, ts, on ^ ACT_LOW};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      check(tag_q.pop_front(), act_word, exp_q.pop_front());
    end
  end

  // driver: called just after the negedge that enters T1; garbage opcode during fetch
  task automatic run_instr(input logic [3:0] op, input int last_step);
    for (int s = 1; s <= last_step; s++) begin
      opcode = (s < 4) ? 4'($urandom_range(0, 15)) : op;
      exp_q.push_back(model_word(s, op, 1'b0));
      tag_q.push_back($sformatf("op%h_T%0d", op, s));
      if (s < last_step) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  task automatic run_full(input logic [3:0] op);
    run_instr(op, 6);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int wait_cycles;
    logic [3:0] rop;
    rst_n  = 1'b0;
    opcode = 4'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hold", act_word, model_word(1, opcode, 1'b0));
    rst_n = 1'b1;

    run_full(4'b0000);
    run_full(4'b0001);
    run_full(4'b0010);
    run_full(4'b1110);
    run_full(4'b0011);
    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 14));
      run_full(rop);
    end

    // asynchronous reset while in T5
    run_instr(4'b0001, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_T5", act_word, model_word(1, opcode, 1'b0));
    @(negedge clk);
    #1;
    check("reset_hold_edge", act_word, model_word(1, opcode, 1'b0));
    rst_n = 1'b1;
    run_full(4'b0000);

    // HLT: freeze at T4 for 10 further clocks, then reset restarts
    run_instr(4'b1111, 4);
    @(negedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      opcode = 4'($urandom_range(0, 15));
      exp_q.push_back(model_word(4, 4'hf, 1'b1));
      tag_q.push_back($sformatf("halted_%0d", i));
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("halt_reset", act_word, model_word(1, opcode, 1'b0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    run_full(4'b0000);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
